// File: rtl/mem_access.sv
// mem_access: memory stage between execute and writeback; byte/half/word accesses over a req/ack bus
package mem_access_pkg;
    typedef struct packed {
        logic       mem;
        logic       iop;
        logic [2:0] fcs_opcode;
        logic [4:0] rd;
    } control_s;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  control_s        i_control_signal,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_done,
    input  logic            i_wb_ready,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_fault,
    output logic [1:0]      o_fault_cause,
    output logic [1:0]      o_current_state
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, COMPLETE = 2'd2} state_e;

    state_e          state_q;
    logic            ready_q, req_q, we_q, done_q, fault_q;
    logic [XLEN-1:0] addr_q, wdata_q, rd_q;
    logic [3:0]      be_q;
    logic [1:0]      cause_q;
    control_s        ctrl_q;
    logic [CW-1:0]   cnt_q;

    logic            illegal_in, misal_in;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in, shifted, rd_d;
    logic            sext;

    // decode size legality, alignment and bus lanes of the incoming instruction
    always_comb begin
        illegal_in = !(i_control_signal.fcs_opcode inside {3'b000, 3'b001, 3'b010}
                       || (!i_control_signal.iop && i_control_signal.fcs_opcode inside {3'b100, 3'b101}));
        misal_in   = (i_control_signal.fcs_opcode[1:0] == 2'b01 && i_alu_result[0])
                  || (i_control_signal.fcs_opcode[1:0] == 2'b10 && i_alu_result[1:0] != 2'b00);
        be_in      = i_control_signal.fcs_opcode[1:0] == 2'b00 ? 4'b0001 << i_alu_result[1:0]
                   : i_control_signal.fcs_opcode[1:0] == 2'b01 ? 4'b0011 << i_alu_result[1:0]
                   : 4'b1111;
        wdata_in   = i_control_signal.fcs_opcode[1:0] == 2'b00 ? {(XLEN/8){i_rs2[7:0]}}
                   : i_control_signal.fcs_opcode[1:0] == 2'b01 ? {(XLEN/16){i_rs2[15:0]}}
                   : i_rs2;
    end

    // align and extend the returned read word into writeback data
    always_comb begin
        shifted = i_dmem_rdata >> {addr_q[1:0], 3'b000};
        sext    = ~ctrl_q.fcs_opcode[2];
        rd_d    = ctrl_q.iop ? '0
                : ctrl_q.fcs_opcode[1:0] == 2'b00 ? {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]}
                : ctrl_q.fcs_opcode[1:0] == 2'b01 ? {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]}
                : shifted;
    end

    // stage FSM with registered bus and writeback outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            be_q    <= '0;
            cause_q <= 2'b00;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && i_valid) begin
                        ready_q <= 1'b0;
                        ctrl_q  <= i_control_signal;
                        addr_q  <= i_alu_result;
                        wdata_q <= wdata_in;
                        cnt_q   <= '0;
                        if (!i_control_signal.mem) begin
                            rd_q    <= i_alu_result;
                            cause_q <= 2'b00;
                            fault_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= COMPLETE;
                        end else if (illegal_in || misal_in) begin
                            rd_q    <= '0;
                            cause_q <= illegal_in ? 2'b10 : 2'b01;
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= COMPLETE;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= i_control_signal.iop;
                            be_q    <= be_in;
                            cause_q <= 2'b00;
                            fault_q <= 1'b0;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (i_dmem_ack || cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        rd_q    <= i_dmem_ack ? rd_d : '0;
                        cause_q <= i_dmem_ack ? 2'b00 : 2'b11;
                        fault_q <= !i_dmem_ack;
                        state_q <= COMPLETE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                COMPLETE: begin
                    if (i_wb_ready) begin
                        done_q  <= 1'b0;
                        fault_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready          = ready_q;
    assign o_dmem_req       = req_q;
    assign o_dmem_we        = we_q;
    assign o_dmem_addr      = addr_q;
    assign o_dmem_be        = be_q;
    assign o_dmem_wdata     = wdata_q;
    assign o_done           = done_q;
    assign o_control_signal = ctrl_q;
    assign o_rd_data        = rd_q;
    assign o_fault          = fault_q;
    assign o_fault_cause    = cause_q;
    assign o_current_state  = state_q;
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of `execute`.
- Accepts one instruction per handshake:
  - the `control_s` bundle,
  - the ALU result (effective address for loads/stores, rd data otherwise),
  - store data from rs2.
- Performs byte/half/word data-memory accesses over a req/ack bus and produces aligned, sign- or zero-extended load data.
- Hands the result to writeback with a valid/ready handshake and flags misaligned, illegal-size and bus-timeout faults.

Parameters:
- XLEN, 32, datapath width.
- ACK_TIMEOUT, 16, max cycles `o_dmem_req` may wait for `i_dmem_ack` before fault (≥1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  execute result valid (execute `o_done`).
- o_ready  out  1  stage can accept a new instruction.
- i_control_signal  in  control_s  uses `.mem`, `.iop` (1=store, 0=load), `.fcs_opcode[2:0]`.
- i_alu_result  in  XLEN  address (mem) or rd data (non-mem).
- i_rs2  in  XLEN  store data.
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  1=write.
- o_dmem_addr  out  XLEN  byte address, unmodified.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  XLEN  lane-replicated store data.
- i_dmem_ack  in  1  bus completion, one cycle.
- i_dmem_rdata  in  XLEN  read word, valid with ack.
- o_done  out  1  result valid to writeback.
- i_wb_ready  in  1  writeback accepts.
- o_control_signal  out  control_s  captured control bundle.
- o_rd_data  out  XLEN  writeback data.
- o_fault  out  1  fault on this instruction.
- o_fault_cause  out  2  01 misaligned, 10 illegal size, 11 timeout, 00 none.
- o_current_state  out  2  FSM state, for verification.

Behaviour:
- Reset (async, `i_reset_n`=0):
  - state=IDLE; `o_ready`=0 while reset is asserted;
  - `o_dmem_req`/`o_dmem_we`/`o_done`/`o_fault`=0; `o_dmem_be`=0;
  - addr/wdata/`o_rd_data`=0; cause=00; control captured as all-zero (nop); timeout counter=0.
  - Reset mid-access drops req immediately. A late ack after reset is ignored.
- FSM states: IDLE(0), REQ(1), COMPLETE(2).
- IDLE:
  - `o_ready`=1; on `i_valid`, register all inputs.
  - Non-mem: `o_rd_data`=`i_alu_result` → COMPLETE.
  - Mem with legal size and aligned address → REQ.
  - Otherwise fault → COMPLETE with `o_rd_data`=0 and no bus access.
- Size decode (`fcs_opcode`):
  - 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (load only).
  - Stores allow 000/001/010 only; any other code gives cause 10.
  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00; violation gives cause 01.
  - Illegal size takes priority over misaligned.
- REQ:
  - `o_dmem_req`=1; addr/be/we/wdata held stable until ack.
  - be: byte = 1<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - wdata: byte replicated ×4, half replicated ×2, word as-is.
  - On ack → COMPLETE, same cycle req deasserts (registered).
  - Load data: shift `i_dmem_rdata` right by 8·addr[1:0], then sign-extend (000/001) or zero-extend (100/101). Stores give `o_rd_data`=0.
  - Timeout counter counts REQ cycles without ack. When it reaches ACK_TIMEOUT → COMPLETE with cause 11 and `o_rd_data`=0.
  - Ack on the same cycle as expiry wins: no fault.
- COMPLETE:
  - `o_done`=1; all outputs held until `i_wb_ready`=1, then → IDLE.
  - `o_ready` returns the next cycle (no bypass accept in COMPLETE).
  - `o_fault`=(cause≠00).
- Latency:
  - Non-mem: accept at cycle N, `o_done` at N+1.
  - Mem: req at N+1; ack at N+1+k (k≥0); `o_done` at N+2+k.
- Throughput: at most one instruction per 2 cycles non-mem, 3+k mem.
- `i_valid` while `o_ready`=0 is ignored; upstream holds it.

Test Plan:
1. ADD passthrough: `i_alu_result`=0x0000_1234, mem=0 → `o_done` next cycle, `o_rd_data`=0x1234, no req.
2. LB at addr 0x103, `i_dmem_rdata`=0x80FF_FFFF, ack k=2 → be=1000, `o_rd_data`=0xFFFF_FF80; LBU same → 0x0000_0080; `o_done` at N+4.
3. SH at addr 0x202, rs2=0xAAAA_BEEF → be=1100, wdata=0xBEEF_BEEF, we=1, `o_rd_data`=0.
4. LW at addr 0x105 → cause=01, `o_fault`=1, `o_dmem_req` never asserted; SB with `fcs_opcode`=100 → cause=10.
5. LW with no ack, ACK_TIMEOUT=16 → req high 16 cycles, then `o_done` with cause=11; ack exactly at expiry → no fault.
6. Backpressure plus reset: hold `i_wb_ready`=0 for 5 cycles → outputs stable and `o_ready`=0; assert `i_reset_n`=0 mid-REQ → req=0 immediately, state IDLE, later ack ignored.
